nibble_serial_tx: RTL and testbench
===================================

# nibble_serial_tx

Serial transmitter that takes parallel words from the registered async-reset data path and shifts them onto a single wire as framed serial bits: start bit, data LSB first, optional even parity, stop bit. It is the sending end of the path whose receiving end captures nibbles into async-reset flip-flops. A valid/ready handshake on the parallel side decouples the producer from the serial bit rate.

## Interface
- DATA_W, 4, data bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
- PARITY_EN, 1, 1 inserts an even-parity bit after data; 0 omits it
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  transmitter can accept a word this cycle
- in_data  input  DATA_W  word to send, sampled on the accepting edge
- tx_out  output  1  serial line, idle high, registered
- busy  output  1  frame in progress, registered
- done  output  1  one-cycle pulse in the last cycle of the stop bit

## Operation
- Transfer occurs on a rising clk edge where in_valid && in_ready; in_data is copied into an internal shift register and parity (^in_data) is latched at that edge.
- in_ready = ~busy (combinational). No transfer can occur while rst is low.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1, busy=0. On transfer -> START.
  - START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_out = shift_reg[0]; after each CLKS_PER_BIT cycles shift right; after DATA_W bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx_out = latched parity for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles; done=1 in final cycle -> IDLE.
- in_valid held high while busy is ignored; the word is taken only once busy falls.
- in_data changes while busy have no effect on the frame in flight.
- Bit-cycle counter width: clog2(CLKS_PER_BIT), wraps to 0 on each bit boundary; bit index counter width clog2(DATA_W+1).

## Timing
- Reset (rst low, asynchronous): tx_out=1, busy=0, done=0, state=IDLE, counters=0, shift register=0; in_ready reads 1. Reset mid-frame aborts immediately; line returns high without waiting for clk.
- First clk edge after rst rises acts normally; a transfer may happen on that edge.
- Latency: tx_out goes 0 on the accepting edge itself (registered output updates at that edge); busy rises on the same edge.
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles from accept edge to the edge where busy falls.
- done pulses exactly one cycle, coincident with the last STOP cycle; busy falls on the following edge.
- Back-to-back: earliest next accept is the edge at which busy has fallen plus one (one full IDLE cycle of tx_out=1 between frames).
- CLKS_PER_BIT=1: every state lasts one cycle; no zero-length bits.

## Structure
- Shared package: FSM state enumeration (IDLE, START, DATA, PARITY, STOP) and a function returning frame length in cycles for given DATA_W, CLKS_PER_BIT, PARITY_EN, reused by the matching receiver bench.
- One sub-module: bit_timer (CLKS_PER_BIT counter, async active-low reset, outputs bit_tick at end of each bit period, restart input on accept).
- FSM, shift register and parity latch live in nibble_serial_tx.

## Test plan
- Defaults, rst low 15 ns then high, in_data=4'b1010 with in_valid for one cycle -> tx_out 0,0,1,0,1,0,1 each held 4 cycles (start, data LSB first, parity 0, stop); busy high 28 cycles; done one pulse.
- in_data=4'b1011 -> data bits 1,1,0,1, parity bit 1; frame 28 cycles.
- in_valid held high with 4'b0001 then 4'b1111 -> two frames separated by exactly one idle cycle; second word is the value present on the second accept edge.
- rst driven low mid-DATA between clock edges -> tx_out=1, busy=0 immediately, no done pulse; next frame after release is complete and correct.
- PARITY_EN=0, CLKS_PER_BIT=1, in_data=4'b0110 -> tx_out 0,0,1,1,0,1 over 6 cycles, done in cycle 6.
- in_data toggled every cycle while busy -> transmitted bits match only the accepted word.

Source files
------------

// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and helpers for the nibble serial link: frame FSM states and
// the frame-length calculation used by both the transmitter and receiver benches.
package nibble_serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Cycles from the accepting edge to the edge where busy falls.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit, input int parity_en);
    return (2 + data_w + ((parity_en != 0) ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit while a frame runs,
// flags the final cycle of each bit (bit_tick) and the cycle before it (pre_tick).
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = run && (cnt_q == LAST);

  // pre_tick means the count after this edge will be the last of its bit.
  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      assign pre_tick = run;
    end else begin : g_multi
      assign pre_tick = run && (cnt_q == CW'(CLKS_PER_BIT - 2));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed serial transmitter: start bit, data LSB first, optional even parity, stop bit,
// fed by a valid/ready handshake. All line-side outputs are registered.
module nibble_serial_tx
  import nibble_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              bit_tick;
  logic              pre_tick;

  assign in_ready = ~busy_q;
  assign accept   = in_valid && in_ready;
  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .run     (busy_q),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  // tx_out_d always carries the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (accept) begin
          state_d   = START;
          shift_d   = in_data;
          parity_d  = ^in_data;
          bit_idx_d = '0;
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_out_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            state_d  = (PARITY_EN != 0) ? PARITY : STOP;
            tx_out_d = (PARITY_EN != 0) ? parity_q : 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_out_d  = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d  = STOP;
          tx_out_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d  = IDLE;
          tx_out_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
    done_d = (state_d == STOP) && pre_tick;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: two configurations, a frame-level reference model
// compared every cycle, plus literal waveform checks for the directed cases.
module tb_nibble_serial_tx;

  localparam int CPB_A = 4;
  localparam int PAR_A = 1;
  localparam int TOT_A = (2 + 4 + PAR_A) * CPB_A;
  localparam int CPB_B = 1;
  localparam int PAR_B = 0;
  localparam int TOT_B = (2 + 4 + PAR_B) * CPB_B;

  logic       clk;
  logic       rst;
  logic       in_valid_a, in_valid_b;
  logic [3:0] in_data_a, in_data_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB_A), .PARITY_EN(PAR_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .tx_out(tx_a), .busy(busy_a), .done(done_a)
  );

  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB_B), .PARITY_EN(PAR_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .tx_out(tx_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list: [0]=start, [1..dw]=data LSB first, then parity, then stop.
  function automatic logic [18:0] frame_bits(input logic [15:0] d, input int dw, input int par);
    logic [18:0] f;
    logic        p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < dw; i++) begin
      f[i+1] = d[i];
      p = p ^ d[i];
    end
    if (par != 0) f[dw+1] = p;
    f[dw+1+par] = 1'b1;
    return f;
  endfunction

  // Reference model: pos = cycle index within the current frame, -1 when idle.
  int          pos_a = -1, pos_b = -1;
  logic [18:0] fb_a, fb_b;
  logic [3:0]  last_word_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_a <= -1;
    end else if (pos_a >= 0) begin
      pos_a <= (pos_a + 1 == TOT_A) ? -1 : pos_a + 1;
    end else if (in_valid_a) begin
      fb_a        <= frame_bits({12'd0, in_data_a}, 4, PAR_A);
      last_word_a <= in_data_a;
      pos_a       <= 0;
      $display("txn A: accepted word %h at %0t", in_data_a, $time);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_b <= -1;
    end else if (pos_b >= 0) begin
      pos_b <= (pos_b + 1 == TOT_B) ? -1 : pos_b + 1;
    end else if (in_valid_b) begin
      fb_b  <= frame_bits({12'd0, in_data_b}, 4, PAR_B);
      pos_b <= 0;
      $display("txn B: accepted word %h at %0t", in_data_b, $time);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("a_tx",    tx_a,       (pos_a < 0) ? 1'b1 : fb_a[pos_a / CPB_A]);
      check("a_busy",  busy_a,     pos_a >= 0);
      check("a_done",  done_a,     pos_a == TOT_A - 1);
      check("a_ready", in_ready_a, pos_a < 0);
      check("b_tx",    tx_b,       (pos_b < 0) ? 1'b1 : fb_b[pos_b / CPB_B]);
      check("b_busy",  busy_b,     pos_b >= 0);
      check("b_done",  done_b,     pos_b == TOT_B - 1);
      check("b_ready", in_ready_b, pos_b < 0);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a;
    int k;
    k = 0;
    while (busy_a && k < 200) begin
      step();
      k++;
    end
    check("a_idle_timeout", busy_a, 1'b0);
  endtask

  // Sends one word on A and checks the literal line level mid-bit for all 7 bits.
  task automatic directed_a(input logic [3:0] word, input logic [6:0] lit, input string tag);
    int n_busy;
    int n_done;
    in_valid_a = 1'b1;
    in_data_a  = word;
    step();
    in_valid_a = 1'b0;
    n_busy = 0;
    n_done = 0;
    for (int c = 0; c < TOT_A; c++) begin
      if (c % CPB_A == 1) check({tag, "_bit"}, tx_a, lit[c / CPB_A]);
      if (busy_a) n_busy++;
      if (done_a) n_done++;
      if (c == TOT_A - 1) check({tag, "_done_last"}, done_a, 1'b1);
      step();
    end
    check_int({tag, "_busy_cycles"}, n_busy, 28);
    check_int({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_after"}, busy_a, 1'b0);
  endtask

  initial begin
    logic [6:0] lit_1010;
    logic [6:0] lit_1011;
    logic [5:0] lit_0110;
    int         idle;
    int         k;

    lit_1010 = 7'b1010100;
    lit_1011 = 7'b1110110;
    lit_0110 = 6'b101100;

    rst        = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_data_a  = 4'h0;
    in_data_b  = 4'h0;

    #12;
    check("rst_tx_a",    tx_a,       1'b1);
    check("rst_busy_a",  busy_a,     1'b0);
    check("rst_done_a",  done_a,     1'b0);
    check("rst_ready_a", in_ready_a, 1'b1);
    check("rst_tx_b",    tx_b,       1'b1);
    #3 rst = 1'b1;
    step();

    directed_a(4'b1010, lit_1010, "f1010");
    directed_a(4'b1011, lit_1011, "f1011");

    // Held valid: second word is whatever is present on the second accept edge.
    in_valid_a = 1'b1;
    in_data_a  = 4'b0001;
    step();
    in_data_a = 4'b1111;
    wait_idle_a();
    idle = 0;
    k = 0;
    while (!busy_a && k < 50) begin
      idle++;
      step();
      k++;
    end
    in_valid_a = 1'b0;
    check_int("b2b_gap", idle, 1);
    check_int("b2b_word", int'(last_word_a), 15);
    wait_idle_a();
    step();

    // Asynchronous reset mid-DATA, between clock edges.
    in_valid_a = 1'b1;
    in_data_a  = 4'h6;
    step();
    in_valid_a = 1'b0;
    repeat (9) step();
    #1 rst = 1'b0;
    #1;
    check("midrst_tx",    tx_a,       1'b1);
    check("midrst_busy",  busy_a,     1'b0);
    check("midrst_done",  done_a,     1'b0);
    check("midrst_ready", in_ready_a, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    directed_a(4'b1011, lit_1011, "postrst");

    // Configuration B: no parity, one cycle per bit.
    in_valid_b = 1'b1;
    in_data_b  = 4'b0110;
    step();
    in_valid_b = 1'b0;
    for (int c = 0; c < TOT_B; c++) begin
      check("b0110_bit", tx_b, lit_0110[c]);
      check("b0110_done", done_b, c == TOT_B - 1);
      step();
    end
    check("b0110_busy_after", busy_b, 1'b0);

    // Random traffic; data toggles every cycle, including mid-frame.
    for (int i = 0; i < 800; i++) begin
      in_valid_a = ($urandom_range(0, 3) != 0);
      in_data_a  = 4'($urandom);
      in_valid_b = ($urandom_range(0, 2) != 0);
      in_data_b  = 4'($urandom);
      step();
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    wait_idle_a();
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
